// File: rtl/msm_pkg.sv
// Shared MSM scheduler definitions: FSM state encoding, issue source encoding,
// default parameter constants and a counter-width helper.
package msm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  localparam logic SRC_PM = 1'b0;
  localparam logic SRC_RB = 1'b1;

  localparam int DEF_WIDTH_ID     = 2;
  localparam int DEF_PADD_LATENCY = 21;
  localparam int DEF_STARVE_MAX   = 4;

  // Width of a counter that must hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/padd_tag_pipe.sv
// Valid/ID delay line shadowing the point-adder pipeline; a tag presented on
// the input emerges exactly PADD_LATENCY cycles later.
module padd_tag_pipe #(
  parameter int WIDTH_ID     = 2,
  parameter int PADD_LATENCY = 21
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  input  logic [WIDTH_ID-1:0] in_id,
  output logic                out_vld,
  output logic [WIDTH_ID-1:0] out_id
);

  logic [PADD_LATENCY-1:0] vld_sr;
  logic [WIDTH_ID-1:0]     id_sr [PADD_LATENCY];

  // IDs are zeroed on entry when not valid so out_id stays 0 between results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < PADD_LATENCY; i++) id_sr[i] <= '0;
    end else begin
      vld_sr[0] <= in_vld;
      id_sr[0]  <= in_vld ? in_id : '0;
      for (int i = 1; i < PADD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

  assign out_vld = vld_sr[PADD_LATENCY-1];
  assign out_id  = id_sr[PADD_LATENCY-1];

endmodule

// File: rtl/padd_sched.sv
// Point-adder issue scheduler: arbitrates point-memory and result-buffer
// requests into the PADD pipeline while keeping each bucket ID single-in-flight.
module padd_sched
  import msm_pkg::*;
#(
  parameter int WIDTH_ID     = DEF_WIDTH_ID,
  parameter int PADD_LATENCY = DEF_PADD_LATENCY,
  parameter int STARVE_MAX   = DEF_STARVE_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   flush,
  input  logic                   pm_vld,
  input  logic [WIDTH_ID-1:0]    pm_id,
  output logic                   pm_rdy,
  input  logic                   rb_vld,
  input  logic [WIDTH_ID-1:0]    rb_id,
  output logic                   rb_rdy,
  output logic                   issue_vld,
  output logic                   issue_src,
  output logic [WIDTH_ID-1:0]    issue_id,
  output logic                   out_vld,
  output logic [WIDTH_ID-1:0]    out_id,
  output logic [2**WIDTH_ID-1:0] busy_mask,
  output logic                   done
);

  localparam int NUM_ID = 2**WIDTH_ID;
  localparam int CNT_W  = cnt_width(PADD_LATENCY);
  localparam int STV_W  = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = {CNT_W{1'b1}};
  localparam logic [STV_W-1:0] STV_ONE   = STV_W'(1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  sched_state_t      state;
  logic [CNT_W-1:0]  inflight_cnt;
  logic [CNT_W-1:0]  inflight_nxt;
  logic [STV_W-1:0]  starve_cnt;
  logic [NUM_ID-1:0] retire_mask;
  logic [NUM_ID-1:0] issue_mask;
  logic [NUM_ID-1:0] avail_mask;
  logic              pm_window;
  logic              rb_window;
  logic              pm_elig;
  logic              rb_elig;
  logic              pm_forced;
  logic              grant_pm;
  logic              grant_rb;

  // The retiring ID is treated as free so it can be re-issued in the same cycle.
  always_comb begin
    retire_mask = '0;
    if (out_vld) retire_mask[out_id] = 1'b1;
    avail_mask = ~(busy_mask & ~retire_mask);
  end

  always_comb begin
    pm_window = (state == ST_RUN);
    rb_window = (state == ST_RUN) || (state == ST_DRAIN);
    pm_elig   = pm_window && pm_vld && avail_mask[pm_id];
    rb_elig   = rb_window && rb_vld && avail_mask[rb_id];
    pm_forced = pm_elig && (starve_cnt == STV_LIMIT);
    grant_rb  = rb_elig && !pm_forced;
    grant_pm  = pm_elig && !grant_rb;
  end

  assign pm_rdy    = grant_pm;
  assign rb_rdy    = grant_rb;
  assign issue_vld = grant_pm || grant_rb;
  assign issue_src = grant_rb ? SRC_RB : SRC_PM;
  assign issue_id  = grant_rb ? rb_id : pm_id;

  always_comb begin
    issue_mask = '0;
    if (issue_vld) issue_mask[issue_id] = 1'b1;
  end

  always_comb begin
    case ({issue_vld, out_vld})
      2'b10:   inflight_nxt = inflight_cnt + CNT_ONE;
      2'b01:   inflight_nxt = inflight_cnt - CNT_ONE;
      default: inflight_nxt = inflight_cnt;
    endcase
  end

  padd_tag_pipe #(
    .WIDTH_ID     (WIDTH_ID),
    .PADD_LATENCY (PADD_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (issue_vld),
    .in_id   (issue_id),
    .out_vld (out_vld),
    .out_id  (out_id)
  );

  // Set wins over clear when an ID retires and is re-issued together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_mask    <= '0;
      inflight_cnt <= '0;
      starve_cnt   <= '0;
    end else begin
      busy_mask    <= (busy_mask & ~retire_mask) | issue_mask;
      inflight_cnt <= inflight_nxt;
      if (pm_elig && grant_rb) starve_cnt <= starve_cnt + STV_ONE;
      else                     starve_cnt <= '0;
      assert (!(issue_vld && !out_vld && inflight_cnt == CNT_FULL));
      assert (!(out_vld && !issue_vld && inflight_cnt == '0));
    end
  end

  // Drain completes on the edge where the last result leaves, so done
  // follows the final out_vld by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE:  if (start) state <= ST_RUN;
        ST_RUN:   if (flush) state <= ST_DRAIN;
        ST_DRAIN: begin
          if ((inflight_nxt == '0) && !rb_vld) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_padd_sched.sv
// Self-checking bench for padd_sched: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based model of in-flight operations.
module tb_padd_sched;

  localparam int W   = 3;
  localparam int L   = 21;
  localparam int SM  = 4;
  localparam int NID = 2**W;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic           clk = 1'b0;
  logic           rst_n, start, flush, pm_vld, rb_vld;
  logic [W-1:0]   pm_id, rb_id;
  logic           pm_rdy, rb_rdy, issue_vld, issue_src, out_vld, done;
  logic [W-1:0]   issue_id, out_id;
  logic [NID-1:0] busy_mask;

  always #5 clk = ~clk;

  padd_sched #(.WIDTH_ID(W), .PADD_LATENCY(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .pm_vld(pm_vld), .pm_id(pm_id), .pm_rdy(pm_rdy),
    .rb_vld(rb_vld), .rb_id(rb_id), .rb_rdy(rb_rdy),
    .issue_vld(issue_vld), .issue_src(issue_src), .issue_id(issue_id),
    .out_vld(out_vld), .out_id(out_id), .busy_mask(busy_mask), .done(done)
  );

  typedef struct {
    int t;
    int id;
  } op_t;

  op_t inflight[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  mstate   = M_IDLE;
  int  starve   = 0;
  bit  check_en = 1'b0;
  int  done_seen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock of stimulus: drive, compare at the falling edge, advance the model.
  task automatic applyStimulus(input logic s, input logic f, input logic pv, input int pi,
                               input logic rv, input int ri, input logic rn);
    logic [NID-1:0] e_busy;
    logic           e_out, pm_el, rb_el, e_pm, e_rb;
    int             e_oid;
    start = s; flush = f; pm_vld = pv; pm_id = W'(pi);
    rb_vld = rv; rb_id = W'(ri); rst_n = rn;
    @(negedge clk);
    e_busy = '0; e_out = 1'b0; e_oid = 0;
    foreach (inflight[k]) begin
      e_busy[inflight[k].id] = 1'b1;
      if (inflight[k].t + L == cyc) begin
        e_out = 1'b1;
        e_oid = inflight[k].id;
      end
    end
    pm_el = (mstate == M_RUN) && pv && !(e_busy[pi] && !(e_out && e_oid == pi));
    rb_el = (mstate == M_RUN || mstate == M_DRAIN) && rv && !(e_busy[ri] && !(e_out && e_oid == ri));
    e_rb  = rb_el && !(pm_el && starve == SM);
    e_pm  = pm_el && !e_rb;
    if (done) done_seen++;
    if (check_en) begin
      checkOutput("pm_rdy", 32'(pm_rdy), 32'(e_pm));
      checkOutput("rb_rdy", 32'(rb_rdy), 32'(e_rb));
      checkOutput("issue_vld", 32'(issue_vld), 32'(e_pm || e_rb));
      if (e_pm || e_rb) begin
        checkOutput("issue_src", 32'(issue_src), 32'(e_rb));
        checkOutput("issue_id", 32'(issue_id), e_rb ? ri : pi);
      end
      checkOutput("out_vld", 32'(out_vld), 32'(e_out));
      checkOutput("out_id", 32'(out_id), e_oid);
      checkOutput("busy_mask", 32'(busy_mask), 32'(e_busy));
      checkOutput("done", 32'(done), 32'(mstate == M_DONE));
    end
    @(posedge clk);
    if (!rn) begin
      inflight.delete();
      mstate = M_IDLE;
      starve = 0;
    end else begin
      for (int k = inflight.size() - 1; k >= 0; k--)
        if (inflight[k].t + L <= cyc) inflight.delete(k);
      if (e_pm || e_rb) inflight.push_back('{t: cyc, id: (e_rb ? ri : pi)});
      starve = (pm_el && e_rb) ? starve + 1 : 0;
      case (mstate)
        M_IDLE:  if (s) mstate = M_RUN;
        M_RUN:   if (f) mstate = M_DRAIN;
        M_DRAIN: if (inflight.size() == 0 && !rv) mstate = M_DONE;
        default: mstate = M_IDLE;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    check_en = 1'b1;
    idleCycles(2);

    // Back-to-back pm issues of IDs 0..3
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, i, 1'b0, 0, 1'b1);
    checkOutput("busy_peak", 32'(busy_mask), 32'h0F);
    idleCycles(24);

    // Held pm request on a busy ID; re-issue on the retire cycle
    for (int i = 0; i < 24; i++) applyStimulus(1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 1'b1);
    idleCycles(22);

    // Starvation limit: rb wins four times, pm wins the fifth
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 7, 1'b1, i, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 4, 1'b1);
    idleCycles(22);

    // Busy rb ID lets a free pm ID through
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 1'b1, 1, 1'b1);
    idleCycles(22);

    // Random traffic in RUN
    for (int i = 0; i < 200; i++)
      applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, NID-1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, NID-1)), 1'b1);
    idleCycles(22);

    // Flush with three in flight, pm kept requesting during drain
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, i, 1'b0, 0, 1'b1);
    done_seen = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 40 && mstate != M_IDLE; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 5, 1'b0, 0, 1'b1);
    checkOutput("drain_to_idle", 32'(mstate == M_IDLE), 32'd1);
    checkOutput("done_pulses", 32'(done_seen), 32'd1);
    idleCycles(2);

    // Random control and traffic, including ignored start/flush
    for (int i = 0; i < 150; i++)
      applyStimulus(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, NID-1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, NID-1)), 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    idleCycles(25);

    // Reset with five in flight discards every tag
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, i, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    checkOutput("busy_after_reset", 32'(busy_mask), 32'd0);
    idleCycles(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
